fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 19 +
 rtl/pc_next_logic.sv | 42 ++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch slice.
// Holds the FSM state encoding, the default reset fetch address, the opcodes
// the decoder cares about, and a helper that builds branch byte offsets.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    // Fetch FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_FETCH = 2'd1;
    localparam state_t S_VALID = 2'd2;

    // Opcodes seen on instr[31:26].
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    // Sign-extended 16-bit word displacement converted to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read bus.
// Handshake: the master holds imem_req=1 and a stable imem_addr until a cycle
// in which the slave returns imem_ready=1; imem_rdata is valid only in that
// cycle. Only one request is outstanding at a time.
//   imem_req   : read request (master -> slave)
//   imem_addr  : word-aligned read address (master -> slave)
//   imem_ready : read data valid this cycle (slave -> master)
//   imem_rdata : instruction word (slave -> master)
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ready, input imem_rdata);
    modport slave  (input  imem_req, input imem_addr,
                    output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection for the instruction held in decode.
//   pc_plus4_i     : address of the held instruction plus 4
//   instr_idx_i    : instr[25:0] (jump index; [15:0] is the branch immediate)
//   rs_data_i      : register jump target
//   branch_eq_i, branch_ne_i, jump_i, jump_src_i, zero_i : decoded control
//   next_pc_o      : selected next fetch address
//   misaligned_o   : register jump target with nonzero low bits
module pc_next_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [25:0] instr_idx_i,
    input  logic [31:0] rs_data_i,
    input  logic        branch_eq_i,
    input  logic        branch_ne_i,
    input  logic        jump_i,
    input  logic        jump_src_i,
    input  logic        zero_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    logic branch_taken;

    // Both branch flags set means "taken if either condition holds".
    assign branch_taken = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);

    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jump_i && jump_src_i) begin
            // Low bits are forced to zero; misalignment is flagged separately.
            next_pc_o = {rs_data_i[31:2], 2'b00};
        end else if (jump_i) begin
            next_pc_o = {pc_plus4_i[31:28], instr_idx_i, 2'b00};
        end else if (branch_taken) begin
            next_pc_o = pc_plus4_i + branch_offset(instr_idx_i[15:0]);
        end
    end

    assign misaligned_o = jump_i & jump_src_i & (|rs_data_i[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit.
// Fetches a word at pc, holds it for decode until accepted, then moves pc to
// the selected next address and fetches again.
//   clk, reset      : clock (rising edge), asynchronous active-low reset
//   imem            : instruction memory bus (master side)
//   instr, op       : held instruction word and its opcode field
//   instr_valid     : held instruction is valid for decode
//   pc_plus4        : address of the held instruction plus 4
//   id_ready        : decode accepts the held instruction
//   branch_eq, branch_ne, jump, jump_src, zero, rs_data : control for the
//                     held instruction, used only on acceptance
//   addr_err        : pulse on acceptance of a misaligned register jump
//   fetch_count     : number of instructions accepted by decode
//   state_dbg       : current FSM state
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic [5:0]   op,
    output logic [31:0]  pc_plus4,
    input  logic         id_ready,
    input  logic         branch_eq,
    input  logic         branch_ne,
    input  logic         jump,
    input  logic         jump_src,
    input  logic         zero,
    input  logic [31:0]  rs_data,
    output logic         addr_err,
    output logic [31:0]  fetch_count,
    output state_t       state_dbg
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        accept;

    assign accept = (state_q == S_VALID) && id_ready;

    pc_next_logic u_pc_next (
        .pc_plus4_i   (pc_plus4),
        .instr_idx_i  (instr_q[25:0]),
        .rs_data_i    (rs_data),
        .branch_eq_i  (branch_eq),
        .branch_ne_i  (branch_ne),
        .jump_i       (jump),
        .jump_src_i   (jump_src),
        .zero_i       (zero),
        .next_pc_o    (next_pc),
        .misaligned_o (misaligned)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem.imem_ready) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (id_ready) begin
                    pc_d    = next_pc;
                    count_d = count_q + 32'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = (state_q == S_VALID);
    assign op             = instr_q[31:26];
    assign pc_plus4       = pc_q + 32'd4;
    // Combinational so it lasts exactly the acceptance cycle; state is IDLE
    // during reset, which keeps it low.
    assign addr_err       = accept & misaligned;
    assign fetch_count    = count_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import mips_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  op;
    logic [31:0] pc_plus4;
    logic        id_ready;
    logic        branch_eq, branch_ne, jump, jump_src, zero;
    logic [31:0] rs_data;
    logic        addr_err;
    logic [31:0] fetch_count;
    state_t      state_dbg;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .op          (op),
        .pc_plus4    (pc_plus4),
        .id_ready    (id_ready),
        .branch_eq   (branch_eq),
        .branch_ne   (branch_ne),
        .jump        (jump),
        .jump_src    (jump_src),
        .zero        (zero),
        .rs_data     (rs_data),
        .addr_err    (addr_err),
        .fetch_count (fetch_count),
        .state_dbg   (state_dbg)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Returns one word for the pending request; ends on the negedge after capture.
    task automatic fetch(input logic [31:0] word, input logic [31:0] exp_addr, input string tag);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'd1);
        chk({tag, "_addr"}, bus.imem_addr, exp_addr);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_instr"}, instr, word);
        chk({tag, "_pc4"}, pc_plus4, exp_addr + 32'd4);
    endtask

    task automatic accept(input logic bq, input logic bn, input logic j, input logic js,
                          input logic z, input logic [31:0] rs, input logic [31:0] exp_pc,
                          input logic exp_err, input string tag);
        branch_eq = bq; branch_ne = bn; jump = j; jump_src = js; zero = z; rs_data = rs;
        id_ready  = 1'b1;
        #1;
        chk({tag, "_err"}, 32'(addr_err), 32'(exp_err));
        @(negedge clk);
        id_ready  = 1'b0;
        branch_eq = 1'b0; branch_ne = 1'b0; jump = 1'b0; jump_src = 1'b0; zero = 1'b0;
        rs_data   = 32'h0;
        exp_count = exp_count + 32'd1;
        chk({tag, "_next"}, bus.imem_addr, exp_pc);
        chk({tag, "_cnt"}, fetch_count, exp_count);
        chk({tag, "_vfall"}, 32'(instr_valid), 32'd0);
        chk({tag, "_errfall"}, 32'(addr_err), 32'd0);
    endtask

    task automatic nop_step(input logic [31:0] addr);
        fetch(32'h0, addr, "nop");
        accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, addr + 32'd4, 1'b0, "nop");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0;
        bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
        id_ready = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0;
        jump = 1'b0; jump_src = 1'b0; zero = 1'b0; rs_data = 32'h0;

        #12;
        chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
        chk("rst_addr", bus.imem_addr, 32'h0040_0000);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_cnt", fetch_count, 32'h0);

        // Release: one IDLE cycle, then FETCH at the reset address.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        chk("fetch_state", 32'(state_dbg), 32'(S_FETCH));
        fetch(32'h0, 32'h0040_0000, "first");
        chk("first_op", 32'(op), 32'h0);
        accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0004, 1'b0, "first");

        // BEQ at 0x0040_0010, imm=-4 words, taken and not taken.
        nop_step(32'h0040_0004);
        nop_step(32'h0040_0008);
        nop_step(32'h0040_000C);
        fetch(32'h1000_FFFC, 32'h0040_0010, "beq_t");
        chk("beq_op", 32'(op), 32'(OP_BEQ));
        accept(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0040_0004, 1'b0, "beq_t");
        nop_step(32'h0040_0004);
        nop_step(32'h0040_0008);
        nop_step(32'h0040_000C);
        fetch(32'h1000_FFFC, 32'h0040_0010, "beq_nt");
        accept(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0014, 1'b0, "beq_nt");

        // Both branch flags with zero=0: the ne condition holds, so taken.
        fetch(32'h1400_FFFC, 32'h0040_0014, "both");
        chk("bne_op", 32'(op), 32'(OP_BNE));
        accept(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0008, 1'b0, "both");

        // J into 0x0040_0020, then J at 0x0040_0020 with index 26'h010_0040.
        fetch(32'h0810_0008, 32'h0040_0008, "j1");
        chk("j_op", 32'(op), 32'(OP_J));
        accept(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0020, 1'b0, "j1");
        fetch(32'h0810_0040, 32'h0040_0020, "j2");
        accept(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0100, 1'b0, "j2");

        // Register jump with misaligned target; a taken branch is also flagged
        // to show the register jump wins.
        fetch(32'h03E0_0008, 32'h0040_0100, "jr");
        accept(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0033, 32'h0040_0030, 1'b1, "jr");

        // Decode stall for 5 cycles; spurious imem_ready for 3 of them and
        // control inputs toggling are ignored.
        fetch(32'hDEAD_BEEF, 32'h0040_0030, "stall");
        for (int i = 0; i < 5; i++) begin
            bus.imem_ready = (i < 3);
            bus.imem_rdata = 32'h1234_5678;
            jump = 1'b1; jump_src = 1'b1; rs_data = 32'hFFFF_FFFF;
            #1;
            chk("stall_err", 32'(addr_err), 32'd0);
            @(negedge clk);
            chk("stall_instr", instr, 32'hDEAD_BEEF);
            chk("stall_op", 32'(op), 32'h37);
            chk("stall_pc4", pc_plus4, 32'h0040_0034);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_cnt", fetch_count, exp_count);
        end
        bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
        jump = 1'b0; jump_src = 1'b0; rs_data = 32'h0;
        accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0034, 1'b0, "stall");

        // Address wrap at the top of the space.
        fetch(32'h0, 32'h0040_0034, "towrap");
        accept(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, "towrap");
        fetch(32'h0, 32'hFFFF_FFFC, "wrap");
        accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b0, "wrap");

        // Reset while FETCH waits; a response arriving in IDLE is not captured.
        #2;
        reset = 1'b0;
        #1;
        exp_count = 32'h0;
        chk("rf_state", 32'(state_dbg), 32'(S_IDLE));
        chk("rf_req", 32'(bus.imem_req), 32'd0);
        chk("rf_addr", bus.imem_addr, 32'h0040_0000);
        chk("rf_cnt", fetch_count, 32'h0);
        chk("rf_instr", instr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        bus.imem_ready = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
        chk("stale_state", 32'(state_dbg), 32'(S_FETCH));
        chk("stale_instr", instr, 32'h0);
        chk("stale_valid", 32'(instr_valid), 32'd0);

        // Reset while VALID holds an instruction.
        fetch(32'hCAFE_F00D, 32'h0040_0000, "rv");
        #2;
        reset = 1'b0;
        #1;
        chk("rv_valid", 32'(instr_valid), 32'd0);
        chk("rv_instr", instr, 32'h0);
        chk("rv_state", 32'(state_dbg), 32'(S_IDLE));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
